// File: rtl/kcpsmx_call_stack_if.sv
// Bus bundle for the KCPSMX call/return stack: command strobes, push data,
// top-of-stack data and status/error flags.
interface kcpsmx_call_stack_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 31
) ();
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             flush;
  logic             clear_err;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] top_data;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, flush, clear_err, data_in,
    input  top_data, count, full, empty, overflow, underflow
  );

  modport slave (
    input  push, pop, flush, clear_err, data_in,
    output top_data, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/kcpsmx_call_stack.sv
// Self-addressed call/return stack with modulo-DEPTH pointer, occupancy count,
// replace-top, flush, and sticky overflow/underflow flags (wrap or saturate).
module kcpsmx_call_stack #(
  parameter int WIDTH     = 10,
  parameter int DEPTH     = 31,
  parameter int WRAP_MODE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  kcpsmx_call_stack_if.slave     bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] ptr_inc_s, ptr_dec_s, mem_waddr_s;
  logic             mem_we_s, full_s, empty_s, ovf_set_s, unf_set_s;

  assign full_s    = (count_q == CNT_FULL);
  assign empty_s   = (count_q == CNT_W'(0));
  assign ptr_inc_s = (wr_ptr_q == PTR_MAX) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
  assign ptr_dec_s = (wr_ptr_q == PTR_W'(0)) ? PTR_MAX : wr_ptr_q - PTR_W'(1);

  // Next-state: flush wins; push+pop on a non-empty stack rewrites the top in place.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = wr_ptr_q;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else if (bus.push && bus.pop && !empty_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = ptr_dec_s;
    end else if (bus.push) begin
      if (!full_s) begin
        mem_we_s = 1'b1;
        wr_ptr_d = ptr_inc_s;
        count_d  = count_q + CNT_W'(1);
      end else if (WRAP_MODE != 0) begin
        mem_we_s  = 1'b1;
        wr_ptr_d  = ptr_inc_s;
        ovf_set_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else if (bus.pop) begin
      if (!empty_s) begin
        wr_ptr_d = ptr_dec_s;
        count_d  = count_q - CNT_W'(1);
      end else if (WRAP_MODE != 0) begin
        wr_ptr_d  = ptr_dec_s;
        unf_set_s = 1'b1;
      end else begin
        unf_set_s = 1'b1;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    // A new error event in the same cycle as clear_err leaves the flag set.
    overflow_d  = (bus.clear_err ? 1'b0 : overflow_q)  | ovf_set_s;
    underflow_d = (bus.clear_err ? 1'b0 : underflow_q) | unf_set_s;
  end

  // Pointer, occupancy and error-flag state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Entry storage, deliberately not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we_s && reset) begin
      mem_q[mem_waddr_s] <= bus.data_in;
    end
  end

  assign bus.top_data  = empty_s ? WIDTH'(0) : mem_q[ptr_dec_s];
  assign bus.count     = count_q;
  assign bus.full      = full_s;
  assign bus.empty     = empty_s;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule
